// File: rtl/sdram_req_arbiter_pkg.sv
// Shared definitions for the SDRAM request arbiter: FSM state encoding and
// default refresh timing.
package sdram_req_arbiter_pkg;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_REF  = 2'd1,
        A_CMD  = 2'd2,
        A_WAIT = 2'd3
    } arb_state_t;

    // 7.8us refresh interval at 133MHz
    localparam int unsigned REF_PERIOD_DFLT   = 1040;
    localparam int unsigned REF_PEND_MAX_DFLT = 8;

endpackage

// File: rtl/sdram_req_arbiter_ref_timer.sv
// Refresh interval timer. Counts REF_PERIOD cycles once init is done and keeps
// a saturating count of refreshes owed to the SDRAM; flags when it saturates.
module sdram_ref_timer
    import sdram_req_arbiter_pkg::*;
#(
    parameter int unsigned REF_PERIOD   = REF_PERIOD_DFLT,
    parameter int unsigned REF_PEND_MAX = REF_PEND_MAX_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic dec,
    output logic ref_pend_nz,
    output logic ref_overrun
);

    localparam int unsigned CNT_W  = $clog2(REF_PERIOD);
    localparam int unsigned PEND_W = $clog2(REF_PEND_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_PERIOD - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(REF_PEND_MAX);

    logic [CNT_W-1:0]  r_cnt;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              r_overrun;
    logic              w_wrap;
    logic              w_dec;

    assign w_wrap      = enable && (r_cnt == CNT_LAST);
    assign w_dec       = dec && (r_pend != '0);
    assign ref_pend_nz = (r_pend != '0);
    assign ref_overrun = r_overrun;

    // Period counter: held at zero until init completes, then free-running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending count: a wrap and an issue in the same cycle cancel out
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wrap && !w_dec && (r_pend != PEND_MAX)) begin
            w_pend_nxt = r_pend + 1'b1;
        end else if (!w_wrap && w_dec) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    // Pending count register and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_pend_nxt == PEND_MAX) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Front end of sdram_core: issues periodic auto-refresh and round-robin
// client read/write commands, one access in flight at a time.
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned REF_PERIOD   = REF_PERIOD_DFLT,
    parameter int unsigned REF_PEND_MAX = REF_PEND_MAX_DFLT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sdram_init_done,
    input  logic                      core_idle,
    input  logic                      sdram_ref_ack,
    input  logic                      sdram_rd_ack,
    input  logic                      sdram_wr_ack,
    output logic                      sdram_ref_req,
    output logic                      sdram_rd_req,
    output logic                      sdram_wr_req,
    output logic [ADDR_W-1:0]         sdram_addr,
    input  logic [NUM_REQ-1:0]        cli_req,
    input  logic [NUM_REQ-1:0]        cli_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] cli_addr,
    output logic [NUM_REQ-1:0]        cli_grant,
    output logic [NUM_REQ-1:0]        cli_ack,
    output logic [NUM_REQ-1:0]        cli_done,
    output logic                      ref_overrun
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state, w_state_nxt;
    logic               r_ref_req, w_ref_req_nxt;
    logic               r_rd_req, w_rd_req_nxt;
    logic               r_wr_req, w_wr_req_nxt;
    logic               r_wr, w_wr_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [IDX_W-1:0]   r_rr, w_rr_nxt;

    logic               w_ref_pend_nz;
    logic               w_ref_dec;
    logic [IDX_W:0]     w_pick;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [ADDR_W-1:0]  w_win_addr;

    // Returns {found, index}: first requester strictly after 'last', wrapping
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        int unsigned      pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            pos = 32'(last) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    sdram_ref_timer #(
        .REF_PERIOD   (REF_PERIOD),
        .REF_PEND_MAX (REF_PEND_MAX)
    ) u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (sdram_init_done),
        .dec         (w_ref_dec),
        .ref_pend_nz (w_ref_pend_nz),
        .ref_overrun (ref_overrun)
    );

    assign w_pick  = rr_pick(cli_req, r_rr);
    assign w_found = w_pick[IDX_W];
    assign w_win   = w_pick[IDX_W-1:0];

    // Address mux for the round-robin winner
    always_comb begin
        w_win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_win_addr = cli_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state, registered-output next values and the single-cycle client pulses
    always_comb begin
        w_state_nxt   = r_state;
        w_ref_req_nxt = r_ref_req;
        w_rd_req_nxt  = r_rd_req;
        w_wr_req_nxt  = r_wr_req;
        w_wr_nxt      = r_wr;
        w_grant_nxt   = r_grant;
        w_addr_nxt    = r_addr;
        w_rr_nxt      = r_rr;
        w_ref_dec     = 1'b0;
        cli_ack       = '0;
        cli_done      = '0;
        case (r_state)
            A_IDLE: begin
                if (sdram_init_done && core_idle) begin
                    if (w_ref_pend_nz) begin
                        w_ref_req_nxt = 1'b1;
                        w_state_nxt   = A_REF;
                    end else if (w_found) begin
                        w_grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                        w_addr_nxt   = w_win_addr;
                        w_wr_nxt     = cli_wr[w_win];
                        w_wr_req_nxt = cli_wr[w_win];
                        w_rd_req_nxt = !cli_wr[w_win];
                        w_rr_nxt     = w_win;
                        w_state_nxt  = A_CMD;
                    end
                end
            end
            A_REF: begin
                if (sdram_ref_ack) begin
                    w_ref_req_nxt = 1'b0;
                    w_ref_dec     = 1'b1;
                    w_state_nxt   = A_WAIT;
                end
            end
            A_CMD: begin
                if ((r_wr && sdram_wr_ack) || (!r_wr && sdram_rd_ack)) begin
                    w_rd_req_nxt = 1'b0;
                    w_wr_req_nxt = 1'b0;
                    cli_ack      = r_grant;
                    w_state_nxt  = A_WAIT;
                end
            end
            A_WAIT: begin
                // Entered the cycle after the ack, so the ack-cycle idle is never seen here;
                // refresh leaves r_grant at zero, so no done pulse for it
                if (core_idle) begin
                    cli_done    = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = A_IDLE;
                end
            end
            default: begin
                w_state_nxt = A_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= A_IDLE;
            r_ref_req <= 1'b0;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
            r_wr      <= 1'b0;
            r_grant   <= '0;
            r_addr    <= '0;
            r_rr      <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_ref_req <= w_ref_req_nxt;
            r_rd_req  <= w_rd_req_nxt;
            r_wr_req  <= w_wr_req_nxt;
            r_wr      <= w_wr_nxt;
            r_grant   <= w_grant_nxt;
            r_addr    <= w_addr_nxt;
            r_rr      <= w_rr_nxt;
        end
    end

    assign sdram_ref_req = r_ref_req;
    assign sdram_rd_req  = r_rd_req;
    assign sdram_wr_req  = r_wr_req;
    assign sdram_addr    = r_addr;
    assign cli_grant     = r_grant;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter with a small behavioural sdram_core
// responder (ack two cycles after a request, then busy for a few cycles).
module tb_sdram_req_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned AW  = 24;
    localparam int unsigned PER = 1040;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sdram_init_done = 1'b0;
    logic            core_idle = 1'b1;
    logic            sdram_ref_ack = 1'b0;
    logic            sdram_rd_ack = 1'b0;
    logic            sdram_wr_ack = 1'b0;
    logic            sdram_ref_req, sdram_rd_req, sdram_wr_req;
    logic [AW-1:0]   sdram_addr;
    logic [NR-1:0]   cli_req = '0;
    logic [NR-1:0]   cli_wr = '0;
    logic [NR*AW-1:0] cli_addr;
    logic [NR-1:0]   cli_grant, cli_ack, cli_done;
    logic            ref_overrun;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned n_mutex = 0;
    int unsigned ref_rise[$];
    int          ev[$];
    logic        prev_ref = 1'b0;

    // 0 = normal core, 1 = held busy (no acks), 2 = long busy after ack
    int unsigned core_mode = 0;
    int unsigned busy = 0;
    int unsigned dly = 0;

    sdram_req_arbiter #(
        .NUM_REQ      (NR),
        .ADDR_W       (AW),
        .REF_PERIOD   (PER),
        .REF_PEND_MAX (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .core_idle       (core_idle),
        .sdram_ref_ack   (sdram_ref_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_ref_req   (sdram_ref_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_addr      (sdram_addr),
        .cli_req         (cli_req),
        .cli_wr          (cli_wr),
        .cli_addr        (cli_addr),
        .cli_grant       (cli_grant),
        .cli_ack         (cli_ack),
        .cli_done        (cli_done),
        .ref_overrun     (ref_overrun)
    );

    always #5 clk = ~clk;

    // Core responder, driven just after the rising edge
    always begin
        @(posedge clk);
        #1;
        sdram_ref_ack = 1'b0;
        sdram_rd_ack  = 1'b0;
        sdram_wr_ack  = 1'b0;
        if (core_mode == 1) begin
            core_idle = 1'b0;
            busy = 0;
            dly  = 0;
        end else if (busy != 0) begin
            busy--;
            core_idle = (busy == 0);
        end else begin
            core_idle = 1'b1;
            if (sdram_ref_req || sdram_rd_req || sdram_wr_req) begin
                if (dly == 1) begin
                    dly = 0;
                    sdram_ref_ack = sdram_ref_req;
                    sdram_rd_ack  = sdram_rd_req;
                    sdram_wr_ack  = sdram_wr_req;
                    core_idle = 1'b0;
                    busy = (core_mode == 2) ? 40 : 3;
                end else begin
                    dly++;
                end
            end else begin
                dly = 0;
            end
        end
    end

    // Event log: refresh accepts (100) and client accepts (index)
    always @(negedge clk) begin
        cyc++;
        if ((int'(sdram_ref_req) + int'(sdram_rd_req) + int'(sdram_wr_req)) > 1) n_mutex++;
        if (sdram_ref_req && !prev_ref) ref_rise.push_back(cyc);
        prev_ref = sdram_ref_req;
        if (sdram_ref_req && sdram_ref_ack) ev.push_back(100);
        for (int i = 0; i < NR; i++) begin
            if (cli_ack[i]) ev.push_back(i);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NR-1:0] oh);
        for (int i = 0; i < NR; i++) begin
            if (oh[i]) return i;
        end
        return 99;
    endfunction

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] wr;
        logic [NR-1:0] exp_grant;
        logic [AW-1:0] exp_addr;
        logic          exp_wr;
    } vec_t;

    initial begin
        vec_t        vec [9];
        int          exp_rr [5];
        int          ack_idx [5];
        int unsigned c, nack, ndone, nbad, start, t;
        int          nref;
        logic        got, done_seen;
        logic [NR-1:0] ack_v, grant_v;
        logic [AW-1:0] addr_v;
        logic        wrq_v, rdq_v;

        cli_addr = {24'hFFFFFF, 24'h2B0C0D, 24'h123456, 24'h0A0000};

        vec[0] = '{4'b0001, 4'b0000, 4'b0001, 24'h0A0000, 1'b0};
        vec[1] = '{4'b0001, 4'b0001, 4'b0001, 24'h0A0000, 1'b1};
        vec[2] = '{4'b1001, 4'b0000, 4'b1000, 24'hFFFFFF, 1'b0};
        vec[3] = '{4'b1001, 4'b1000, 4'b0001, 24'h0A0000, 1'b0};
        vec[4] = '{4'b0110, 4'b0100, 4'b0010, 24'h123456, 1'b0};
        vec[5] = '{4'b0110, 4'b0100, 4'b0100, 24'h2B0C0D, 1'b1};
        vec[6] = '{4'b1111, 4'b1111, 4'b1000, 24'hFFFFFF, 1'b1};
        vec[7] = '{4'b0100, 4'b0000, 4'b0100, 24'h2B0C0D, 1'b0};
        vec[8] = '{4'b1000, 4'b0000, 4'b1000, 24'hFFFFFF, 1'b0};
        exp_rr = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (3) tick();
        check("rst_reqs", {sdram_ref_req, sdram_rd_req, sdram_wr_req}, 3'b000);
        check("rst_addr", sdram_addr, 24'h0);
        rst = 1'b0;
        tick();
        check("rst_grant", cli_grant, 4'b0);
        check("rst_ack_done", {cli_ack, cli_done}, 8'h00);
        check("rst_overrun", ref_overrun, 1'b0);

        // Init gate: nothing issued while init is incomplete
        cli_req = 4'b0001;
        nbad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (sdram_ref_req || sdram_rd_req || sdram_wr_req || (cli_grant != 0)) nbad++;
        end
        check("init_gate_quiet", nbad, 0);

        // Table-driven arbitration vectors
        sdram_init_done = 1'b1;
        ev.delete();
        for (int v = 0; v < 9; v++) begin
            cli_req = vec[v].req;
            cli_wr  = vec[v].wr;
            got = 1'b0;
            c = 0;
            ack_v = '0; grant_v = '0; addr_v = '0; wrq_v = 1'b0; rdq_v = 1'b0;
            while (!got && c < 100) begin
                tick();
                c++;
                if (cli_ack != 0) begin
                    got = 1'b1;
                    ack_v = cli_ack; grant_v = cli_grant; addr_v = sdram_addr;
                    wrq_v = sdram_wr_req; rdq_v = sdram_rd_req;
                end
            end
            cli_req = '0;
            check($sformatf("vec%0d_ack", v), ack_v, vec[v].exp_grant);
            check($sformatf("vec%0d_grant", v), grant_v, vec[v].exp_grant);
            check($sformatf("vec%0d_addr", v), addr_v, vec[v].exp_addr);
            check($sformatf("vec%0d_dir", v), {wrq_v, rdq_v}, {vec[v].exp_wr, !vec[v].exp_wr});
            done_seen = 1'b0;
            ack_v = '0;
            c = 0;
            while (!done_seen && c < 100) begin
                tick();
                c++;
                if (cli_done != 0) begin
                    done_seen = 1'b1;
                    ack_v = cli_done;
                end
            end
            check($sformatf("vec%0d_done", v), ack_v, vec[v].exp_grant);
            tick();
            check($sformatf("vec%0d_grant_clr", v), cli_grant, 4'b0);
        end
        nbad = 0;
        foreach (ev[i]) if (ev[i] == 100) nbad++;
        check("no_early_ref", nbad, 0);

        // Round robin with all four requesting continuously
        cli_wr = '0;
        cli_req = 4'b1111;
        nack = 0; ndone = 0; c = 0;
        ack_idx = '{99, 99, 99, 99, 99};
        while (ndone < 5 && c < 400) begin
            tick();
            c++;
            if (cli_ack != 0) begin
                if (nack < 5) ack_idx[nack] = oh2idx(cli_ack);
                nack++;
                if (nack == 5) cli_req = '0;
            end
            if (cli_done != 0) ndone++;
        end
        cli_req = '0;
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), ack_idx[i], exp_rr[i]);
        check("rr_ack_count", nack, 5);
        check("rr_done_count", ndone, 5);

        // Refresh cadence with no clients
        ref_rise.delete();
        repeat (3 * PER + 200) tick();
        check("cad_rises", (ref_rise.size() >= 3), 1'b1);
        if (ref_rise.size() >= 3) begin
            check("cad_interval0", ref_rise[1] - ref_rise[0], PER);
            check("cad_interval1", ref_rise[2] - ref_rise[1], PER);
        end

        // Refresh beats a client that becomes eligible in the same idle cycle
        ev.delete();
        core_mode = 1;
        repeat (2) tick();
        cli_req = 4'b0100;
        repeat (PER + 60) tick();
        core_mode = 0;
        got = 1'b0; c = 0;
        while (!got && c < 200) begin
            tick();
            c++;
            if (cli_ack != 0) begin
                got = 1'b1;
                cli_req = '0;
            end
        end
        cli_req = '0;
        repeat (20) tick();
        check("prio_first_ref", (ev.size() > 0) ? ev[0] : 999, 100);
        nref = 0;
        while (nref < ev.size() && ev[nref] == 100) nref++;
        check("prio_then_cli2", (nref < ev.size()) ? ev[nref] : 999, 2);

        // Refresh backlog saturates and raises the sticky overrun
        check("ovr_clear_before", ref_overrun, 1'b0);
        core_mode = 1;
        start = cyc;
        t = ref_rise[ref_rise.size() - 1];
        while (t < start + 9 * PER + 200) t += PER;
        t += 5;
        while (cyc < t) tick();
        check("ovr_set", ref_overrun, 1'b1);
        ev.delete();
        cli_req = 4'b0001;
        cli_wr  = 4'b0000;
        core_mode = 0;
        got = 1'b0; c = 0;
        while (!got && c < 300) begin
            tick();
            c++;
            if (cli_ack != 0) begin
                got = 1'b1;
                cli_req = '0;
            end
        end
        cli_req = '0;
        repeat (20) tick();
        nref = 0;
        while (nref < ev.size() && ev[nref] == 100) nref++;
        check("ovr_ref_count", nref, 8);
        check("ovr_then_cli0", (nref < ev.size()) ? ev[nref] : 999, 0);
        check("ovr_sticky", ref_overrun, 1'b1);

        // Write path, then reset while waiting for the core to finish
        core_mode = 2;
        cli_wr  = 4'b0010;
        cli_req = 4'b0010;
        got = 1'b0; c = 0;
        ack_v = '0; addr_v = '0; wrq_v = 1'b0; rdq_v = 1'b0;
        while (!got && c < 100) begin
            tick();
            c++;
            if (cli_ack != 0) begin
                got = 1'b1;
                ack_v = cli_ack; addr_v = sdram_addr;
                wrq_v = sdram_wr_req; rdq_v = sdram_rd_req;
            end
        end
        cli_req = '0;
        check("wr_ack", ack_v, 4'b0010);
        check("wr_addr", addr_v, 24'h123456);
        check("wr_dir", {wrq_v, rdq_v}, 2'b10);
        tick();
        check("wr_wait_grant", cli_grant, 4'b0010);
        rst = 1'b1;
        tick();
        check("rst_mid_reqs", {sdram_ref_req, sdram_rd_req, sdram_wr_req}, 3'b000);
        check("rst_mid_addr", sdram_addr, 24'h0);
        check("rst_mid_grant", cli_grant, 4'b0);
        check("rst_mid_pulses", {cli_ack, cli_done}, 8'h00);
        check("rst_mid_overrun", ref_overrun, 1'b0);
        rst = 1'b0;
        core_mode = 0;
        nbad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cli_done != 0) nbad++;
            if (sdram_ref_req || sdram_rd_req || sdram_wr_req) nbad++;
        end
        check("rst_no_done", nbad, 0);

        check("req_mutex", n_mutex, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
